// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package instr_fetch_unit_pkg;

  localparam int ADDR_W    = 4;
  localparam int INSTR_W   = 8;
  localparam int PROG_LAST = 5;
  localparam int Q_DEPTH   = 2;

  localparam logic [ADDR_W-1:0] PROG_LAST_PC = ADDR_W'(PROG_LAST);

  // One fetch-queue slot: the instruction plus the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential program order, wrapping back to 0 after the last program word.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return (pc == PROG_LAST_PC) ? '0 : pc + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry fetch FIFO holding {pc, instr}. Slot 0 is always the head, so the
// head outputs keep their last value once the queue drains.
module instr_fetch_unit_fetch_queue
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic               pop_i,
  input  logic               clear_i,
  output logic [1:0]         count_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  fetch_entry_t pushEntry;

  assign pushEntry    = {push_pc_i, push_instr_i};
  assign count_o      = count_q;
  assign head_pc_o    = entry0_q.pc;
  assign head_instr_o = entry0_q.instr;

  // Next-state: clear drops everything (including a same-cycle push), otherwise shift on pop and fill the first free slot on push.
  always_comb begin
    count_d  = count_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) entry0_d = pushEntry;
          else                 entry1_d = pushEntry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) entry0_d = entry1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            entry0_d = entry1_q;
            entry1_d = pushEntry;
          end else begin
            entry0_d = pushEntry;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      count_q  <= count_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  overflowCheck: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && !clear_i && count_q == 2'd2));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues reads to a 1-cycle synchronous ROM,
// buffers responses in a 2-entry queue and handles jump redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_en_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);

  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0] issuePc_q, issuePc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic [1:0]        queueCount;
  logic [2:0]        occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic [ADDR_W-1:0] redirectTarget;

  // Issue only when the queue is guaranteed a free slot for the response, counting the one still in flight.
  always_comb begin
    pop            = out_valid_o & out_ready_i;
    push           = inflight_q & ~kill_q;
    occupancy      = 3'(queueCount) + 3'(inflight_q) - 3'(pop);
    issue          = ~rst_i & ~redirect_valid_i & (occupancy < 3'(Q_DEPTH));
    redirectTarget = (redirect_pc_i > PROG_LAST_PC) ? '0 : redirect_pc_i;
  end

  assign imem_en_o   = issue;
  assign imem_addr_o = fetchPc_q;
  assign out_valid_o = (queueCount != 2'd0);

  // Next PC / in-flight tracking; a redirect suppresses issue and poisons any response still returning.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    issuePc_d  = issuePc_q;
    inflight_d = 1'b0;
    kill_d     = 1'b0;
    if (redirect_valid_i) begin
      fetchPc_d = redirectTarget;
      kill_d    = inflight_q;
    end else if (issue) begin
      inflight_d = 1'b1;
      issuePc_d  = fetchPc_q;
      fetchPc_d  = next_pc(fetchPc_q);
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetchPc_q  <= '0;
      issuePc_q  <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      issuePc_q  <= issuePc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  instr_fetch_unit_fetch_queue u_fetch_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_pc_i    (issuePc_q),
    .push_instr_i (imem_data_i),
    .pop_i        (pop),
    .clear_i      (redirect_valid_i),
    .count_o      (queueCount),
    .head_pc_o    (out_pc_o),
    .head_instr_o (out_instr_o)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed latency/redirect/reset
// scenarios followed by a randomized run, all checked against a program-order
// stream model through a scoreboard queue.
module tb_instr_fetch_unit;

  localparam int PROG_LAST = 5;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] instr;
  } expItem_t;

  logic       clk;
  logic       rst;
  logic       imem_en;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [3:0] out_pc;
  logic       redirect_valid;
  logic [3:0] redirect_pc;

  logic [7:0] rom [16];
  expItem_t   expQ [$];
  int         modelNextPc;
  logic       pendingRedirect;
  logic [3:0] pendingTarget;
  int         vectorsApplied;
  int         miscompares;
  int         popCount;

  instr_fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_en_o        (imem_en),
    .imem_addr_o      (imem_addr),
    .imem_data_i      (imem_data),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_data <= rom[imem_addr];
  end

  // Compare one observed value against the model's value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Keep the expected program-order stream a few entries ahead of the DUT.
  task automatic topUp();
    while (expQ.size() < 4) begin
      expQ.push_back('{pc: 4'(modelNextPc), instr: rom[modelNextPc]});
      modelNextPc = (modelNextPc + 1) % (PROG_LAST + 1);
    end
  endtask

  // Drive one cycle of inputs and update the reference stream for redirects and resets.
  task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV, input logic [3:0] tgtV);
    @(posedge clk);
    #1;
    if (pendingRedirect) begin
      expQ.delete();
      modelNextPc = (int'(pendingTarget) > PROG_LAST) ? 0 : int'(pendingTarget);
    end
    if (rstV) begin
      expQ.delete();
      modelNextPc = 0;
    end
    rst             = rstV;
    out_ready       = readyV;
    redirect_valid  = redirV & ~rstV;
    redirect_pc     = tgtV;
    pendingRedirect = redirV & ~rstV;
    pendingTarget   = tgtV;
    topUp();
  endtask

  // Monitor: whenever a head is presented it must be the next item of the stream; a handshake consumes it.
  initial begin
    expItem_t item;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("model_has_entry", 32'd0, 32'd1);
        end else begin
          checkOutput("head_pc", 32'(out_pc), 32'(expQ[0].pc));
          checkOutput("head_instr", 32'(out_instr), 32'(expQ[0].instr));
          if (out_ready) begin
            item = expQ.pop_front();
            popCount++;
          end
        end
      end
    end
  end

  // Check the start-up sequence that follows every reset release.
  task automatic checkRestart(input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput({tag, "_c0_imem_en"}, 32'(imem_en), 32'd1);
    checkOutput({tag, "_c0_imem_addr"}, 32'(imem_addr), 32'd0);
    checkOutput({tag, "_c0_valid"}, 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput({tag, "_c1_valid"}, 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput({tag, "_c2_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_c2_pc"}, 32'(out_pc), 32'd0);
  endtask

  // Directed scenarios, then a randomized run.
  initial begin
    int popsBefore;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 4'd0;
    imem_data = 8'h00;
    vectorsApplied = 0; miscompares = 0; popCount = 0;
    pendingRedirect = 1'b0; pendingTarget = 4'd0; modelNextPc = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hA0 + 8'(i);

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_imem_en", 32'(imem_en), 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_instr", 32'(out_instr), 32'd0);
    checkOutput("rst_pc", 32'(out_pc), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);

    // Streaming with ready high: no bubbles across the wrap.
    checkRestart("t1");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      checkOutput("t1_no_bubble", 32'(out_valid), 32'd1);
    end

    // Backpressure from cycle 2: queue fills, fetch stops, head holds pc 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      checkOutput("t2_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_hold_pc", 32'(out_pc), 32'd0);
      checkOutput("t2_hold_instr", 32'(out_instr), 32'hA0);
      checkOutput("t2_imem_idle", 32'(imem_en), 32'd0);
    end
    popsBefore = popCount;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput("t2_drain_pops", 32'(popCount - popsBefore), 32'd3);

    // Redirect to 3 with a full stalled queue.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      checkOutput("t3_valid", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("t3_pc", 32'(out_pc), 32'd3);
    checkOutput("t3_instr", 32'(out_instr), 32'hA3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);

    // Out-of-range target is treated as 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd9);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      checkOutput("t4_valid", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("t4_pc", 32'(out_pc), 32'd0);

    // Back-to-back redirects: the later target wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd2);
    @(negedge clk);
    checkOutput("t5_valid_n1", 32'(out_valid), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      checkOutput("t5_valid", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("t5_pc", 32'(out_pc), 32'd2);

    // Reset while streaming with a fetch in flight.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_pre_imem_en", 32'(imem_en), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_imem_en", 32'(imem_en), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkRestart("t6");

    // Randomized run with a random ROM image.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    popsBefore = popCount;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput("random_progress", 32'(popCount - popsBefore > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
